// File: rtl/rp_8bit_io_pkg.sv
// rp_8bit_io_pkg: shared offsets, control layout and helpers for the I/O timer block
package rp_8bit_io_pkg;
  localparam logic [1:0] OFF_CTL = 2'd0;
  localparam logic [1:0] OFF_CNT = 2'd1;
  localparam logic [1:0] OFF_CMP = 2'd2;
  localparam logic [1:0] OFF_FLG = 2'd3;
  localparam int MAT = 0;
  localparam int OVF = 1;
  typedef struct packed {
    logic [2:0] pre;
    logic       osh;
    logic       ie;
    logic       en;
  } ctl_t;
  function automatic logic [7:0] mw(input logic [7:0] r, input logic [7:0] w, input logic [7:0] m);
    return (r & ~m) | (w & m);
  endfunction
  function automatic logic [7:0] ctl2byte(input ctl_t c);
    return {1'b0, c.pre, 1'b0, c.osh, c.ie, c.en};
  endfunction
endpackage

// File: rtl/rp_8bit_io_tmr_ch.sv
// rp_8bit_io_tmr_ch: one compare-match timer channel with prescaler, flags and irq
module rp_8bit_io_tmr_ch
  import rp_8bit_io_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we_ctl,
  input  logic       we_cnt,
  input  logic       we_cmp,
  input  logic       we_flg,
  input  logic [7:0] wdt,
  input  logic [7:0] msk,
  input  logic       ack,
  output logic [7:0] ctl,
  output logic [7:0] cnt,
  output logic [7:0] cmp,
  output logic [7:0] flg,
  output logic       irq
);
  ctl_t       ctl_q, ctl_d;
  logic [7:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic [1:0] flg_q, flg_d;
  logic [6:0] psc_q, psc_d, pmk;
  logic [5:0] wf, mf;
  logic       clr_en, tick, match, wrap;
  assign wf = {wdt[6:4], wdt[2:0]};
  assign mf = {msk[6:4], msk[2:0]};
  // tick generation, match/overflow, CPU writes and flag set-beats-clear
  always_comb begin
    pmk = 7'((8'd1 << ctl_q.pre) - 8'd1);
    clr_en = we_ctl & msk[0] & ~wdt[0];
    tick = ctl_q.en & ((psc_q & pmk) == pmk) & ~clr_en;
    match = tick & (cnt_q == cmp_q);
    wrap = tick & ~match & (cnt_q == 8'hFF);
    ctl_d = we_ctl ? ctl_t'((6'(ctl_q) & ~mf) | (wf & mf)) : ctl_q;
    if (match & ctl_q.osh & ~(we_ctl & msk[0])) ctl_d.en = 1'b0;
    cnt_d = we_cnt ? mw(cnt_q, wdt, msk) : (match | wrap) ? 8'h00 : tick ? cnt_q + 8'd1 : cnt_q;
    cmp_d = we_cmp ? mw(cmp_q, wdt, msk) : cmp_q;
    flg_d[MAT] = match | (flg_q[MAT] & ~ack & ~(we_flg & wdt[MAT] & msk[MAT]));
    flg_d[OVF] = wrap | (flg_q[OVF] & ~(we_flg & wdt[OVF] & msk[OVF]));
    psc_d = (ctl_q.en & ctl_d.en & ~tick) ? psc_q + 7'd1 : 7'd0;
  end
  // channel state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q <= '0;
      cnt_q <= '0;
      cmp_q <= '0;
      flg_q <= '0;
      psc_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
      flg_q <= flg_d;
      psc_q <= psc_d;
    end
  end
  assign ctl = ctl2byte(ctl_q);
  assign cnt = cnt_q;
  assign cmp = cmp_q;
  assign flg = {6'b0, flg_q};
  assign irq = ctl_q.ie & flg_q[MAT];
endmodule

// File: rtl/rp_8bit_io_tmr.sv
// rp_8bit_io_tmr: CHN compare-match timer channels on the rp_8bit I/O bus
module rp_8bit_io_tmr
  import rp_8bit_io_pkg::*;
#(
  parameter int         CHN = 2,
  parameter logic [5:0] BAS = 6'h20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           io_wen,
  input  logic           io_ren,
  input  logic [5:0]     io_adr,
  input  logic [7:0]     io_wdt,
  input  logic [7:0]     io_msk,
  output logic [7:0]     io_rdt,
  output logic [CHN-1:0] irq_req,
  input  logic [CHN-1:0] irq_ack
);
  localparam int LIM = int'(BAS) + 4 * CHN;
  logic       hit;
  logic [5:0] rel;
  logic [7:0] ctl_v [CHN];
  logic [7:0] cnt_v [CHN];
  logic [7:0] cmp_v [CHN];
  logic [7:0] flg_v [CHN];
  logic [7:0] rdt_q, rdt_d;
  assign hit = (int'(io_adr) >= int'(BAS)) && (int'(io_adr) < LIM);
  assign rel = io_adr - BAS;
  genvar i;
  generate
    for (i = 0; i < CHN; i++) begin : g_ch
      logic sel;
      assign sel = io_wen & hit & (rel[5:2] == 4'(i));
      rp_8bit_io_tmr_ch u_ch (
        .clk    (clk),
        .rst    (rst),
        .we_ctl (sel & (rel[1:0] == OFF_CTL)),
        .we_cnt (sel & (rel[1:0] == OFF_CNT)),
        .we_cmp (sel & (rel[1:0] == OFF_CMP)),
        .we_flg (sel & (rel[1:0] == OFF_FLG)),
        .wdt    (io_wdt),
        .msk    (io_msk),
        .ack    (irq_ack[i]),
        .ctl    (ctl_v[i]),
        .cnt    (cnt_v[i]),
        .cmp    (cmp_v[i]),
        .flg    (flg_v[i]),
        .irq    (irq_req[i])
      );
    end
  endgenerate
  // read mux; unmapped addresses return zero, io_rdt holds between reads
  always_comb begin
    rdt_d = rdt_q;
    if (io_ren) begin
      rdt_d = 8'h00;
      for (int j = 0; j < CHN; j++)
        if (hit && rel[5:2] == 4'(j))
          rdt_d = (rel[1:0] == OFF_CTL) ? ctl_v[j] : (rel[1:0] == OFF_CNT) ? cnt_v[j] :
                  (rel[1:0] == OFF_CMP) ? cmp_v[j] : flg_v[j];
    end
  end
  // registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdt_q <= 8'h00;
    else rdt_q <= rdt_d;
  end
  assign io_rdt = rdt_q;
endmodule

// File: doc/rp_8bit_io_tmr.md
# rp_8bit_io_tmr

Parametrised I/O-bus peripheral for the rp_8bit core. It replaces the flat 64-byte I/O scratch memory used in simulation benches with CHN independent compare-match timer channels. Each channel has masked-write control/count/compare/flag registers and a level interrupt on irq_req with hardware acknowledge on irq_ack. It attaches directly to the core's io_* and irq_* ports, alongside other I/O decoders that share the 6-bit I/O address space.

## Interface
- CHN, 2 — number of timer channels, 1..8
- BAS, 6'h20 — I/O base address, multiple of 4; BAS + 4*CHN <= 64
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- io_wen  input  1  I/O write enable
- io_ren  input  1  I/O read enable
- io_adr  input  6  I/O address
- io_wdt  input  8  write data
- io_msk  input  8  write mask, bit=1 means bit is written
- io_rdt  output  8  read data, registered
- irq_req  output  CHN  level interrupt request, one per channel
- irq_ack  input  CHN  single-cycle interrupt acknowledge from core

## Operation
- Channel ch occupies addresses BAS+4*ch+{0..3}: CTL, CNT, CMP, FLG. All other addresses are unmapped: writes are ignored, reads return 8'h00.
- CTL bit fields:
  - [0] EN, counter enable
  - [1] IE, interrupt enable
  - [2] OSH, one-shot mode
  - [6:4] PRE, tick every 2^PRE clocks
  - [3] and [7] read 0 and ignore writes
- CNT and CMP: 8-bit read/write.
- FLG bit fields: [0] MAT (compare match), [1] OVF (wrap without match). Upper bits read 0.
- Masked write for CTL/CNT/CMP: reg <= (reg & ~io_msk) | (io_wdt & io_msk).
- FLG is write-1-to-clear: a bit is cleared where io_wdt & io_msk = 1.
- Prescaler: 7-bit counter per channel.
  - Held at 0 while EN=0.
  - While EN=1, it increments every clock.
  - Tick when its low PRE bits are all 1; the prescaler then returns to 0.
- On a tick:
  - If CNT==CMP: CNT<=0, MAT<=1, and EN<=0 if OSH=1.
  - Else if CNT==8'hFF: CNT<=0, OVF<=1.
  - Else: CNT<=CNT+1.
- irq_req[ch] = IE & MAT (combinational from registers).
- irq_ack[ch]=1 clears MAT.
- Simultaneous events:
  - Set beats clear: a match in the same cycle as irq_ack or a W1C write leaves MAT=1; the same rule applies to OVF.
  - A CPU write to CNT in a tick cycle wins and the tick increment is discarded. A match is evaluated on the pre-write CNT; its flag still sets.
  - A CPU write clearing EN in a tick cycle suppresses that tick.
  - A one-shot match clearing EN and a CPU write setting EN in the same cycle: the CPU write wins.
- Reset values: every register 0, prescalers 0, io_rdt=8'h00, irq_req='0.

## Timing
- Write takes effect at the clock edge where io_wen=1; the new value is visible to the next cycle's logic.
- Read: io_rdt is valid one cycle after the io_ren cycle and holds its value until the next io_ren.
  - A read in the same cycle as a write to the same register returns the old value.
- Match period is (CMP+1)*2^PRE clocks.
  - Example: PRE=0, CMP=3, CNT=0, EN written at edge 0 → CNT=1,2,3 after edges 1..3; CNT=0 and MAT=1 after edge 4; irq_req high in the cycle after edge 4.
- irq_req drops in the cycle after the irq_ack cycle (unless set-beats-clear applies).
- Asynchronous reset mid-operation clears everything immediately; there is no pending state after release.

## Structure
- Package rp_8bit_io_pkg:
  - register offset constants: CTL=0, CNT=1, CMP=2, FLG=3
  - packed struct typedef for CTL: en, ie, osh, pre
  - FLG bit indices: MAT=0, OVF=1
- Sub-module rp_8bit_io_tmr_ch: one channel with registers, prescaler, match logic and irq. Inputs are per-register write strobes, wdt, msk and irq_ack; outputs are register values and irq.
- Top level: generate loop of CHN channels, address decode, registered read mux.

## Test plan
- Reset: assert rst mid-count with CNT=8'h05 → all registers read 8'h00, irq_req=0, io_rdt=8'h00.
- Masked write: CMP=8'hAA, then write wdt=8'h55, msk=8'h0F → CMP reads 8'hA5. Read of unmapped BAS-1 → 8'h00.
- Periodic match: PRE=0, CMP=3, EN=1, IE=1 → irq_req[0] rises exactly 4 clocks after the EN write. irq_ack[0] pulse → irq_req low next cycle. Next match after 4 more clocks.
- Prescale plus one-shot: PRE=2, CMP=1, OSH=1 → MAT after 8 clocks, then EN reads 0 and CNT stays 0 for the following 100 clocks.
- Overflow: CNT=8'hFE, CMP=8'h10, PRE=0 → after 2 ticks CNT=0, OVF=1, MAT=0. W1C write wdt=8'h02, msk=8'hFF → FLG=8'h00.
- Collisions: irq_ack, and separately FLG W1C, landing on a match edge → MAT stays 1. CNT write 8'h40 on a tick edge → CNT reads 8'h40. CHN=2 channels run concurrently with independent irq_req.
